// File: rtl/fazyrv_rf_xfer_pkg.sv
// Shared types and sizing helpers for the parallel regfile transfer engine.
package fazyrv_rf_xfer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } xfer_state_e;

  // Number of shift cycles needed to rotate a 32-bit register once.
  function automatic int unsigned chunks_f(int unsigned bwidth);
    return 32 / bwidth;
  endfunction

  // Counter width; at least one bit so BWIDTH=32 still has a legal vector.
  function automatic int unsigned cnt_width_f(int unsigned bwidth);
    return (32 / bwidth > 1) ? $clog2(32 / bwidth) : 1;
  endfunction

endpackage

// File: rtl/fazyrv_rf_xfer_if.sv
// Request/response and regfile-side signals of the transfer engine.
// master: the requester together with the regfile; slave: the engine itself.
interface fazyrv_rf_xfer_if #(
  parameter int unsigned BWIDTH = 2
);
  logic              start_i;
  logic              wr_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [4:0]        rd_i;
  logic [31:0]       wdat_i;
  logic              hold_i;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       rs1_dat_o;
  logic [31:0]       rs2_dat_o;
  logic              rf_shft_o;
  logic [4:0]        rf_rs1_o;
  logic [4:0]        rf_rs2_o;
  logic [4:0]        rf_rd_o;
  logic              rf_we_o;
  logic [BWIDTH-1:0] rf_res_o;
  logic [BWIDTH-1:0] rf_ra_i;
  logic [BWIDTH-1:0] rf_rb_i;

  modport master (
    output start_i, wr_i, rs1_i, rs2_i, rd_i, wdat_i, hold_i, rf_ra_i, rf_rb_i,
    input  busy_o, done_o, rs1_dat_o, rs2_dat_o,
    input  rf_shft_o, rf_rs1_o, rf_rs2_o, rf_rd_o, rf_we_o, rf_res_o
  );

  modport slave (
    input  start_i, wr_i, rs1_i, rs2_i, rd_i, wdat_i, hold_i, rf_ra_i, rf_rb_i,
    output busy_o, done_o, rs1_dat_o, rs2_dat_o,
    output rf_shft_o, rf_rs1_o, rf_rs2_o, rf_rd_o, rf_we_o, rf_res_o
  );
endinterface

// File: rtl/fazyrv_chunk_deser.sv
// Shift-right assembler: each enabled cycle a BWIDTH chunk enters at the top,
// so after 32/BWIDTH cycles chunk 0 sits in the low bits.
module fazyrv_chunk_deser #(
  parameter int unsigned BWIDTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [BWIDTH-1:0] din_i,
  output logic [31:0]       dout_o
);

  logic [31:0] data_q;
  logic [31:0] data_d;

  if (BWIDTH == 32) begin : g_full
    assign data_d = din_i;
  end else begin : g_part
    assign data_d = {din_i, data_q[31:BWIDTH]};
  end

  // Assembly register; holds its value while disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_d;
    end
  end

  assign dout_o = data_q;

endmodule

// File: rtl/fazyrv_rf_xfer.sv
// Parallel access engine in front of the chunked shift-register regfile:
// one full rotation pass gathers rs1/rs2 and optionally writes rd.
module fazyrv_rf_xfer
  import fazyrv_rf_xfer_pkg::*;
#(
  parameter int unsigned BWIDTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fazyrv_rf_xfer_if.slave         bus
);

  localparam int unsigned CHUNKS = chunks_f(BWIDTH);
  localparam int unsigned CntW   = cnt_width_f(BWIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(CHUNKS - 1);

  xfer_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic            wr_q;
  logic [31:0]     wdat_q;
  logic            shift_en;

  // Control FSM: latches the request, counts chunks, one-cycle DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // A start in DONE is taken too, giving a one-cycle gap between passes.
          if (bus.start_i) begin
            rs1_q   <= bus.rs1_i;
            rs2_q   <= bus.rs2_i;
            rd_q    <= bus.rd_i;
            wr_q    <= bus.wr_i;
            wdat_q  <= bus.wdat_i;
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          if (!bus.hold_i) begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntMax) begin
              state_q <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign shift_en = (state_q == StShift) && !bus.hold_i;

  assign bus.busy_o    = (state_q == StShift);
  assign bus.done_o    = (state_q == StDone);
  assign bus.rf_shft_o = shift_en;
  assign bus.rf_we_o   = shift_en && wr_q;
  assign bus.rf_res_o  = shift_en ? wdat_q[cnt_q*BWIDTH +: BWIDTH] : '0;
  assign bus.rf_rs1_o  = rs1_q;
  assign bus.rf_rs2_o  = rs2_q;
  assign bus.rf_rd_o   = rd_q;

  // Chunks are captured in the same cycle they may be overwritten, so a read
  // of rd during a write pass sees the old value.
  fazyrv_chunk_deser #(
    .BWIDTH (BWIDTH)
  ) u_deser_rs1 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (shift_en),
    .din_i  (bus.rf_ra_i),
    .dout_o (bus.rs1_dat_o)
  );

  fazyrv_chunk_deser #(
    .BWIDTH (BWIDTH)
  ) u_deser_rs2 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (shift_en),
    .din_i  (bus.rf_rb_i),
    .dout_o (bus.rs2_dat_o)
  );

endmodule

// File: tb/tb_fazyrv_rf_xfer.sv
// Bench for fazyrv_rf_xfer with a behavioural chunked regfile (BWIDTH=2).
module tb_fazyrv_rf_xfer;
  import fazyrv_rf_xfer_pkg::*;

  localparam int BW     = 2;
  localparam int CHUNKS = 16;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] wdat;
    logic [31:0] exp1;
    logic [31:0] exp2;
    int          hold_at;
    int          hold_len;
  } vec_t;

  logic clk_i;
  logic rst_i;
  int   n_checks;
  int   n_pass;
  logic [31:0] regs [32];
  int   ptr;
  logic [63:0] sb_q [$];

  fazyrv_rf_xfer_if #(.BWIDTH(BW)) bus ();

  fazyrv_rf_xfer #(
    .BWIDTH (BW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] init_val(int i);
    case (i)
      5:       return 32'hDEAD_BEEF;
      6:       return 32'h1234_5678;
      9:       return 32'h1111_1111;
      default: return {4{8'(i)}};
    endcase
  endfunction

  // Regfile model: all registers rotate together; reset reinitialises contents.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
      ptr <= 0;
    end else if (bus.rf_shft_o) begin
      if (bus.rf_we_o && bus.rf_rd_o != 5'd0) regs[bus.rf_rd_o][ptr*BW +: BW] <= bus.rf_res_o;
      ptr <= (ptr + 1) % CHUNKS;
    end
  end

  assign bus.rf_ra_i = regs[bus.rf_rs1_o][ptr*BW +: BW];
  assign bus.rf_rb_i = regs[bus.rf_rs2_o][ptr*BW +: BW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: each done pulse pops one expected {rs1, rs2} pair.
  always @(negedge clk_i) begin
    #2;
    if (bus.done_o) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("rs1_dat", bus.rs1_dat_o, e[63:32]);
        chk("rs2_dat", bus.rs2_dat_o, e[31:0]);
      end
    end
  end

  task automatic drive_start(input vec_t v);
    bus.start_i = 1'b1;
    bus.rs1_i   = v.rs1;
    bus.rs2_i   = v.rs2;
    bus.rd_i    = v.rd;
    bus.wr_i    = v.wr;
    bus.wdat_i  = v.wdat;
  endtask

  task automatic run_pass(input vec_t v);
    int shifts = 0;
    int wes = 0;
    int bad = 0;
    int done_cyc = 0;
    @(negedge clk_i);
    drive_start(v);
    sb_q.push_back({v.exp1, v.exp2});
    @(posedge clk_i);
    for (int cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
      @(negedge clk_i);
      bus.start_i = 1'b0;
      bus.hold_i  = (v.hold_len > 0) && (cyc >= v.hold_at) && (cyc < v.hold_at + v.hold_len);
      #1;
      if ((cyc <= CHUNKS + v.hold_len) != bus.busy_o) bad++;
      if (bus.busy_o) begin
        if (bus.rf_shft_o) shifts++;
        if (bus.rf_we_o) wes++;
        if (bus.rf_shft_o == bus.hold_i) bad++;
        if (bus.rf_rs1_o != v.rs1 || bus.rf_rs2_o != v.rs2 || bus.rf_rd_o != v.rd) bad++;
      end else if (bus.rf_shft_o || bus.rf_we_o || bus.rf_res_o != '0) begin
        bad++;
      end
      if (bus.done_o) done_cyc = cyc;
    end
    bus.hold_i = 1'b0;
    chk("done_cycle", done_cyc, CHUNKS + 1 + v.hold_len);
    chk("shift_count", shifts, CHUNKS);
    chk("we_count", wes, v.wr ? CHUNKS : 0);
    chk("pass_pattern", bad, 0);
  endtask

  vec_t vecs [8];

  initial begin
    int dones [3];
    int nd;
    int shifts;
    int bad;
    vec_t v;

    vecs[0] = '{5'd5, 5'd6, 5'd0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678, 0, 0};
    vecs[1] = '{5'd7, 5'd8, 5'd7, 1'b1, 32'hA5A5_0F0F, 32'h0707_0707, 32'h0808_0808, 3, 2};
    vecs[2] = '{5'd7, 5'd5, 5'd0, 1'b0, 32'h0,         32'hA5A5_0F0F, 32'hDEAD_BEEF, 0, 0};
    vecs[3] = '{5'd9, 5'd0, 5'd9, 1'b1, 32'h2222_2222, 32'h1111_1111, 32'h0,         0, 0};
    vecs[4] = '{5'd9, 5'd6, 5'd0, 1'b0, 32'h0,         32'h2222_2222, 32'h1234_5678, 0, 0};
    vecs[5] = '{5'd0, 5'd31, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0,        32'h1F1F_1F1F, 0, 0};
    vecs[6] = '{5'd5, 5'd6, 5'd0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678, 6, 3};
    vecs[7] = '{5'd0, 5'd7, 5'd0, 1'b0, 32'h0,         32'h0,         32'hA5A5_0F0F, 0, 0};

    n_checks = 0;
    n_pass   = 0;
    rst_i    = 1'b1;
    bus.start_i = 1'b0;
    bus.wr_i    = 1'b0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.rd_i    = '0;
    bus.wdat_i  = '0;
    bus.hold_i  = 1'b0;

    repeat (2) @(negedge clk_i);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_shft", bus.rf_shft_o, 0);
    chk("rst_we", bus.rf_we_o, 0);
    chk("rst_rs1_dat", bus.rs1_dat_o, 0);
    chk("rst_rs2_dat", bus.rs2_dat_o, 0);
    chk("rst_addr", {bus.rf_rs1_o, bus.rf_rs2_o, bus.rf_rd_o}, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) run_pass(vecs[i]);

    // Regfile contents: only x7 and x9 were legitimately written.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e;
      e = (i == 7) ? 32'hA5A5_0F0F : (i == 9) ? 32'h2222_2222 : init_val(i);
      chk($sformatf("reg_x%0d", i), regs[i], e);
    end

    // start_i held high: three passes with a single DONE cycle between them.
    v = '{5'd0, 5'd5, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 0, 0};
    @(negedge clk_i);
    drive_start(v);
    for (int k = 0; k < 3; k++) sb_q.push_back({v.exp1, v.exp2});
    @(posedge clk_i);
    nd = 0;
    shifts = 0;
    bad = 0;
    for (int cyc = 1; cyc <= 80 && nd < 3; cyc++) begin
      @(negedge clk_i);
      #1;
      if (bus.rf_shft_o) shifts++;
      if (bus.done_o) begin
        if (bus.busy_o) bad++;
        dones[nd] = cyc;
        nd++;
        if (nd == 3) bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    chk("b2b_done_count", nd, 3);
    chk("b2b_done0", dones[0], 17);
    chk("b2b_done1", dones[1], 34);
    chk("b2b_done2", dones[2], 51);
    chk("b2b_shifts", shifts, 3 * CHUNKS);
    chk("b2b_busy_in_done", bad, 0);
    chk("b2b_x0", regs[0], 0);

    // Reset in SHIFT cycle 5.
    @(negedge clk_i);
    drive_start(vecs[0]);
    @(posedge clk_i);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk_i);
      bus.start_i = 1'b0;
    end
    #1;
    chk("mid_busy_before", bus.busy_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_done", bus.done_o, 0);
    chk("mid_rst_shft", bus.rf_shft_o, 0);
    chk("mid_rst_rs1", bus.rs1_dat_o, 0);
    chk("mid_rst_rs2", bus.rs2_dat_o, 0);
    @(negedge clk_i);
    #1;
    chk("mid_rst_idle", bus.busy_o, 0);
    rst_i = 1'b0;

    // Recovery pass after the regfile has been reinitialised.
    run_pass(vecs[0]);
    repeat (2) @(negedge clk_i);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fazyrv_rf_xfer.md
Name: fazyrv_rf_xfer

Overview:
Transfer engine directly in front of the chunked shift-register regfile (fazyrv_rf_lut).
- Drives the regfile's shift, address, write-enable and result-chunk inputs for one full 32-bit rotation pass.
- During the pass it gathers the rs1/rs2 read chunks into parallel 32-bit words and writes a parallel 32-bit value into rd chunk by chunk.
- Used by load/CSR/debug paths that need parallel regfile access without the serial datapath.

Parameters:
BWIDTH, 2, chunk width in bits. Legal values: 1, 2, 4, 8, 16, 32.
CHUNKS, 32/BWIDTH, localparam, number of shift cycles per pass.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  request a pass; accepted only when busy_o=0
wr_i  in  1  pass also writes rd; sampled with start_i
rs1_i  in  5  read address A; sampled with start_i
rs2_i  in  5  read address B; sampled with start_i
rd_i  in  5  write address; sampled with start_i
wdat_i  in  32  parallel write data; sampled with start_i
hold_i  in  1  stall; freezes the pass for the current cycle
busy_o  out  1  pass in progress
done_o  out  1  one-cycle completion pulse
rs1_dat_o  out  32  assembled rs1 value
rs2_dat_o  out  32  assembled rs2 value
rf_shft_o  out  1  to regfile shft_i
rf_rs1_o, rf_rs2_o, rf_rd_o  out  5 each  to regfile rs1_i/rs2_i/rd_i
rf_we_o  out  1  to regfile we_i
rf_res_o  out  BWIDTH  to regfile res_i
rf_ra_i, rf_rb_i  in  BWIDTH each  from regfile ra_o/rb_o

Behaviour:
- Reset values (async assert, deassert on clk): state=IDLE, counter=0, all outputs 0, latched addresses and wdat 0.
- Regfile contract:
  - ra/rb present chunk 0 (bits BWIDTH-1:0) at the start of a pass.
  - Each shft advances to the next-higher chunk.
  - With we, the current chunk is replaced by res.
  - After CHUNKS shifts the register is back in its original alignment.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_i=1 latches rs1/rs2/rd/wr/wdat, clears the counter and moves to SHIFT.
  - Otherwise stays in IDLE.
- SHIFT:
  - If hold_i=0: rf_shft_o=1; rf_we_o=wr latched; rf_res_o=wdat_q[cnt*BWIDTH +: BWIDTH].
  - If hold_i=0, rs1/rs2 assembly registers shift right by BWIDTH and load rf_ra_i/rf_rb_i into the top chunk; counter increments.
  - If hold_i=1: rf_shft_o=0, rf_we_o=0, counter and assembly registers frozen.
  - When the counter reaches CHUNKS-1 with hold_i=0, the state moves to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o=1 only in SHIFT. A start_i in the DONE cycle is accepted, giving back-to-back passes with a 1-cycle gap.
- Latency with no holds:
  - start accepted at edge 0.
  - SHIFT occupies cycles 1..CHUNKS.
  - done_o is high in cycle CHUNKS+1; rs*_dat_o are valid from that cycle.
  - Each hold cycle adds one cycle.
- rf_* addresses are driven from latched values and are stable for the whole pass. In IDLE/DONE: rf_shft_o=0, rf_we_o=0, rf_res_o=0.
- rs1_dat_o/rs2_dat_o hold their last result until the next accepted start begins shifting.
- Read-during-write (rd==rs1 or rd==rs2 with wr): the read returns the OLD value, because each chunk is sampled before it is overwritten.
- rd=0 with wr: rf_we_o still asserts; the regfile discards the write. Reading x0 returns 0.
- start_i while busy_o=1 is ignored; no queueing.
- Reset mid-pass: the block returns to IDLE immediately. Regfile alignment is then undefined; the system must reinitialise the regfile after reset.

Decomposition:
- Package fazyrv_rf_xfer_pkg holds: the state enum (IDLE/SHIFT/DONE), and a function deriving CHUNKS and the counter width from BWIDTH.
- Sub-module fazyrv_chunk_deser: a BWIDTH-in / 32-out shift-right assembler with enable. Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset, then BWIDTH=2 regfile model preloaded x5=0xDEADBEEF, x6=0x12345678; start rs1=5, rs2=6, wr=0 -> rf_shft_o high 16 cycles, done_o in cycle 17, rs1_dat_o=0xDEADBEEF, rs2_dat_o=0x12345678, model unchanged.
- Start rd=7, wr=1, wdat=0xA5A5_0F0F -> a following read of x7 returns 0xA5A50F0F, all other registers unchanged.
- rs1=rd=9, wr=1, x9=0x11111111, wdat=0x22222222 -> rs1_dat_o=0x11111111; a subsequent read of x9 returns 0x22222222.
- hold_i high for 3 cycles mid-pass -> done_o in cycle 20, rf_shft_o low exactly during the holds, data correct.
- start_i held high throughout -> passes back-to-back with a 1-cycle DONE gap; starts asserted during SHIFT are ignored; wr=1, rd=0 -> x0 still reads 0.
- Assert rst_i at SHIFT cycle 5 -> busy_o, done_o and rf_shft_o drop to 0 asynchronously; rs*_dat_o=0; state is IDLE.
